// File: rtl/cmd_executor.sv
// Command interpreter: decodes 32-bit words from the ring buffer and drives a GPIO register,
// with timed waits, pulses and input polls. Optional retire counter via CMD_EXEC_STATS_EN.
module cmd_executor #(
  parameter int OUT_W     = 16,
  parameter int PULSE_LEN = 4,
  parameter int TIMEOUT   = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      exec_data,
  input  logic             exec_sample,
  input  logic [OUT_W-1:0] in_port,
  output logic             exec_done,
  output logic [OUT_W-1:0] out_port,
  output logic             busy,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic             err_overrun,
  output logic [15:0]      cmd_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_POLL  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [23:0] PULSE_CNT   = 24'(PULSE_LEN - 1);
  localparam logic [23:0] TIMEOUT_CNT = 24'(TIMEOUT);

  logic [2:0]       state_reg, state_next;
  logic [23:0]      cnt_reg, cnt_next;
  logic [OUT_W-1:0] out_reg, out_next;
  logic [3:0]       op_reg;
  logic [23:0]      arg_reg;
  logic             exec_done_reg, busy_reg;
  logic             err_illegal_reg, err_timeout_reg, err_overrun_reg;
  logic [OUT_W-1:0] in_meta_reg, in_sync_reg;
  logic             set_illegal, set_timeout;
  logic             can_accept, accept;
  logic [OUT_W-1:0] arg_bits;
  logic [OUT_W-1:0] idx_hit;
  logic             idx_ok, poll_match;
  logic             unused_bits;

  // Bits [27:24] carry no meaning for any defined opcode.
  assign unused_bits = ^exec_data[27:24];

  assign can_accept = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign accept     = exec_sample && can_accept;
  assign arg_bits   = arg_reg[OUT_W-1:0];

  // One-hot decode of the WAIT_IN bit index; an index past the port width hits nothing.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_idx
    assign idx_hit[gi] = ({28'd0, arg_reg[3:0]} == 32'(gi));
  end

  assign idx_ok     = |idx_hit;
  assign poll_match = ((|(idx_hit & in_sync_reg)) == arg_reg[4]);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    out_next    = out_reg;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = S_EXEC;
      end
      S_EXEC: begin
        state_next = S_DONE;
        case (op_reg)
          4'h0: begin
          end
          4'h1: out_next = arg_bits;
          4'h2: out_next = out_reg | arg_bits;
          4'h3: out_next = out_reg & ~arg_bits;
          4'h4: begin
            cnt_next = arg_reg;
            if (arg_reg != 24'd0) state_next = S_WAIT;
          end
          4'h5: begin
            out_next   = out_reg | arg_bits;
            cnt_next   = PULSE_CNT;
            state_next = S_PULSE;
          end
          4'h6: begin
            if (idx_ok) begin
              cnt_next   = TIMEOUT_CNT;
              state_next = S_POLL;
            end else begin
              set_illegal = 1'b1;
            end
          end
          default: set_illegal = 1'b1;
        endcase
      end
      S_WAIT: begin
        if (cnt_reg == 24'd1) state_next = S_DONE;
        else cnt_next = cnt_reg - 24'd1;
      end
      S_PULSE: begin
        // Clears the pulse bits even if they were already 1 before the pulse.
        if (cnt_reg == 24'd0) begin
          out_next   = out_reg & ~arg_bits;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg - 24'd1;
        end
      end
      S_POLL: begin
        if (poll_match) begin
          state_next = S_DONE;
        end else if (cnt_reg == 24'd0) begin
          set_timeout = 1'b1;
          state_next  = S_DONE;
        end else begin
          cnt_next = cnt_reg - 24'd1;
        end
      end
      S_DONE: begin
        state_next = accept ? S_EXEC : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= 24'd0;
      out_reg         <= '0;
      op_reg          <= 4'd0;
      arg_reg         <= 24'd0;
      exec_done_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      err_illegal_reg <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_overrun_reg <= 1'b0;
      in_meta_reg     <= '0;
      in_sync_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      out_reg       <= out_next;
      exec_done_reg <= (state_next == S_DONE);
      busy_reg      <= (state_next != S_IDLE);
      if (accept) begin
        op_reg  <= exec_data[31:28];
        arg_reg <= exec_data[23:0];
      end
      if (set_illegal) err_illegal_reg <= 1'b1;
      if (set_timeout) err_timeout_reg <= 1'b1;
      if (exec_sample && !can_accept) err_overrun_reg <= 1'b1;
      in_meta_reg <= in_port;
      in_sync_reg <= in_meta_reg;
    end
  end

`ifdef CMD_EXEC_STATS_EN
  logic [15:0] cmd_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmd_count_reg <= 16'h0000;
    else if (state_next == S_DONE) cmd_count_reg <= cmd_count_reg + 16'd1;
  end

  assign cmd_count = cmd_count_reg;
`else
  assign cmd_count = 16'h0000;
`endif

  assign exec_done   = exec_done_reg;
  assign out_port    = out_reg;
  assign busy        = busy_reg;
  assign err_illegal = err_illegal_reg;
  assign err_timeout = err_timeout_reg;
  assign err_overrun = err_overrun_reg;

endmodule

// File: tb/tb_cmd_executor.sv
// Directed bench for cmd_executor: expected retirements are queued at issue and
// compared when exec_done pulses.
module tb_cmd_executor;

  localparam int OUT_W     = 16;
  localparam int PULSE_LEN = 4;
  localparam int TIMEOUT   = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      exec_data = 32'd0;
  logic             exec_sample = 1'b0;
  logic [OUT_W-1:0] in_port = '0;
  logic             exec_done;
  logic [OUT_W-1:0] out_port;
  logic             busy;
  logic             err_illegal, err_timeout, err_overrun;
  logic [15:0]      cmd_count;

  cmd_executor #(.OUT_W(OUT_W), .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .exec_data(exec_data), .exec_sample(exec_sample),
    .in_port(in_port), .exec_done(exec_done), .out_port(out_port), .busy(busy),
    .err_illegal(err_illegal), .err_timeout(err_timeout), .err_overrun(err_overrun),
    .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] out;
    int          lo;
    int          hi;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cc();
`ifdef CMD_EXEC_STATS_EN
    return 16'(exp_count);
`else
    return 16'h0000;
`endif
  endfunction

  // Drive one word for one cycle starting at the current negedge; queue its expectation.
  task automatic issue(input logic [31:0] w, input string tag, input logic [15:0] eo,
                       input int lo, input int hi);
    if (tag != "") exp_q.push_back('{tag, eo, lo, hi});
    exec_data   = w;
    exec_sample = 1'b1;
    @(negedge clk);
    exec_sample = 1'b0;
  endtask

  // Wait (bounded) for exec_done, then pop and compare against the queued expectation.
  task automatic retire(input int lat0, input logic [15:0] probe, output int hi_cnt);
    int   lat;
    exp_t e;
    lat    = lat0;
    hi_cnt = 0;
    e      = '{"none", 16'h0, 0, 0};
    check("scoreboard depth", exp_q.size(), 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    while (exec_done !== 1'b1 && lat < 200) begin
      check({e.tag, " busy"}, busy, 1);
      if (probe != 16'h0 && (out_port & probe) == probe) hi_cnt++;
      @(negedge clk);
      lat++;
    end
    check({e.tag, " done"}, exec_done, 1);
    check($sformatf("%s latency %0d in [%0d,%0d]", e.tag, lat, e.lo, e.hi),
          (lat >= e.lo && lat <= e.hi), 1);
    check({e.tag, " out_port"}, out_port, e.out);
    exp_count++;
    $display("retired %s: latency %0d out_port 0x%04h", e.tag, lat, out_port);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, " single done pulse"}, exec_done, 0);
    check({tag, " busy cleared"}, busy, 0);
  endtask

  initial begin
    int hi;
    int pulses;
    repeat (3) @(negedge clk);
    check("reset out_port", out_port, 0);
    check("reset busy", busy, 0);
    check("reset exec_done", exec_done, 0);
    check("reset errors", {err_illegal, err_timeout, err_overrun}, 0);
    check("reset cmd_count", cmd_count, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'h1000_A5A5, "SET A5A5", 16'hA5A5, 2, 2);
    retire(1, 16'h0, hi);
    idle_check("SET A5A5");
    issue(32'h4000_0005, "WAIT 5", 16'hA5A5, 7, 7);
    retire(1, 16'h0, hi);
    idle_check("WAIT 5");

    // Reset in the middle of a long WAIT aborts without a done pulse.
    issue(32'h4000_0032, "", 16'h0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort out_port", out_port, 0);
    check("abort busy", busy, 0);
    check("abort exec_done", exec_done, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (exec_done === 1'b1) pulses++;
    end
    check("no done after abort", pulses, 0);
    check("abort errors", {err_illegal, err_timeout, err_overrun}, 0);
    check("abort cmd_count", cmd_count, 0);
    $display("reset abort: %0d done pulses", pulses);

    issue(32'h4000_0000, "WAIT 0", 16'h0000, 2, 2);
    retire(1, 16'h0, hi);
    idle_check("WAIT 0");
    issue(32'h2000_00F0, "OR F0", 16'h00F0, 2, 2);
    retire(1, 16'h0, hi);
    idle_check("OR F0");
    issue(32'h3000_0030, "ANDN 30", 16'h00C0, 2, 2);
    retire(1, 16'h0, hi);
    idle_check("ANDN 30");
    check("cmd_count after 3", cmd_count, exp_cc());

    issue(32'h1000_0000, "SET 0", 16'h0000, 2, 2);
    retire(1, 16'h0, hi);
    idle_check("SET 0");
    issue(32'h5000_0003, "PULSE 3", 16'h0000, 2 + PULSE_LEN, 2 + PULSE_LEN);
    retire(1, 16'h0003, hi);
    check("PULSE 3 high cycles", hi, PULSE_LEN);
    idle_check("PULSE 3");

    issue(32'h1000_0001, "SET 1", 16'h0001, 2, 2);
    retire(1, 16'h0, hi);
    idle_check("SET 1");
    issue(32'h5000_0003, "PULSE overlap", 16'h0000, 2 + PULSE_LEN, 2 + PULSE_LEN);
    retire(1, 16'h0003, hi);
    check("PULSE overlap high cycles", hi, PULSE_LEN);
    idle_check("PULSE overlap");

    // Raise in_port[2] ten cycles into the poll; match must retire within 3 cycles.
    issue(32'h6000_0012, "WAIT_IN match", 16'h0000, 12, 13);
    repeat (9) @(negedge clk);
    in_port[2] = 1'b1;
    retire(10, 16'h0, hi);
    in_port = '0;
    idle_check("WAIT_IN match");
    check("no timeout after match", err_timeout, 0);
    repeat (2) @(negedge clk);

    issue(32'h6000_0012, "WAIT_IN timeout", 16'h0000, TIMEOUT + 3, TIMEOUT + 3);
    retire(1, 16'h0, hi);
    idle_check("WAIT_IN timeout");
    check("err_timeout set", err_timeout, 1);

    issue(32'h1000_1234, "SET 1234", 16'h1234, 2, 2);
    retire(1, 16'h0, hi);
    idle_check("SET 1234");
    check("err_illegal clear before F", err_illegal, 0);
    issue(32'hF000_FFFF, "illegal F", 16'h1234, 2, 2);
    retire(1, 16'h0, hi);
    idle_check("illegal F");
    check("err_illegal set", err_illegal, 1);

    check("err_overrun clear before", err_overrun, 0);
    issue(32'h4000_0005, "WAIT 5 overrun", 16'h1234, 7, 7);
    @(negedge clk);
    exec_data   = 32'h1000_FFFF;
    exec_sample = 1'b1;
    @(negedge clk);
    exec_sample = 1'b0;
    retire(3, 16'h0, hi);
    idle_check("WAIT 5 overrun");
    check("err_overrun set", err_overrun, 1);

    // Second word presented in the exec_done cycle is accepted.
    issue(32'h1000_0011, "SET 11", 16'h0011, 2, 2);
    retire(1, 16'h0, hi);
    issue(32'h1000_0022, "SET 22 in DONE", 16'h0022, 2, 2);
    retire(1, 16'h0, hi);
    idle_check("SET 22 in DONE");
    check("final cmd_count", cmd_count, exp_cc());
    check("final sticky errors", {err_illegal, err_timeout, err_overrun}, 3'b111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
